ddrx_mrs_sequencer: RTL and testbench

// - Consumer (slave) end of the controller configuration interface: takes the four
//   19-bit mode-register values msr0..msr3 and issues the DDR mode-register-set

---
 rtl/ddrx_pkg.sv | 51 +++++
 rtl/ddrx_mrs_sequencer_if.sv | 29 ++
 rtl/ddrx_wait_timer.sv | 26 ++
 rtl/ddrx_mrs_sequencer.sv | 158 +++++++++++++++
 tb/tb_ddrx_mrs_sequencer.sv | 374 +++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ddrx_pkg.sv
// Shared DDR command-path types: command encoding struct, fixed encodings and
// mode-register value field helpers.
package ddrx_pkg;

  typedef struct packed {
    logic cs_n;
    logic ras_n;
    logic cas_n;
    logic we_n;
  } cmd_t;

  typedef logic [18:0] msr_t;

  localparam cmd_t CMD_MRS   = '{cs_n: 1'b0, ras_n: 1'b0, cas_n: 1'b0, we_n: 1'b0};
  localparam cmd_t CMD_ZQCL  = '{cs_n: 1'b0, ras_n: 1'b1, cas_n: 1'b1, we_n: 1'b0};
  localparam cmd_t CMD_DESEL = '{cs_n: 1'b1, ras_n: 1'b1, cas_n: 1'b1, we_n: 1'b1};

  // A10 selects the long (ZQCL) calibration.
  localparam logic [15:0] ZQCL_ADDR = 16'h0400;

  localparam int unsigned MSR_BA_HI   = 18;
  localparam int unsigned MSR_BA_LO   = 16;
  localparam int unsigned MSR_ADDR_HI = 15;
  localparam int unsigned MSR_ADDR_LO = 0;

  function automatic logic [2:0] msr_ba(input msr_t msr);
    return msr[MSR_BA_HI:MSR_BA_LO];
  endfunction

  function automatic logic [15:0] msr_addr(input msr_t msr);
    return msr[MSR_ADDR_HI:MSR_ADDR_LO];
  endfunction

  // Issue order is MR2, MR3, MR1, MR0: map step index to register number.
  function automatic logic [1:0] mr_sel(input logic [2:0] idx);
    case (idx)
      3'd0:    return 2'd2;
      3'd1:    return 2'd3;
      3'd2:    return 2'd1;
      default: return 2'd0;
    endcase
  endfunction

  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/ddrx_mrs_sequencer_if.sv
// Configuration values in, mode-register command stream out, between the config
// register block / command arbiter and the MRS sequencer.
interface ddrx_mrs_sequencer_if;

  logic [18:0] msr0;
  logic [18:0] msr1;
  logic [18:0] msr2;
  logic [18:0] msr3;

  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_cs_n;
  logic        cmd_ras_n;
  logic        cmd_cas_n;
  logic        cmd_we_n;
  logic [2:0]  cmd_ba;
  logic [15:0] cmd_addr;

  modport slave (
    input  msr0, msr1, msr2, msr3, cmd_ready,
    output cmd_valid, cmd_cs_n, cmd_ras_n, cmd_cas_n, cmd_we_n, cmd_ba, cmd_addr
  );

  modport master (
    output msr0, msr1, msr2, msr3, cmd_ready,
    input  cmd_valid, cmd_cs_n, cmd_ras_n, cmd_cas_n, cmd_we_n, cmd_ba, cmd_addr
  );

endinterface

// File: rtl/ddrx_wait_timer.sv
// Loadable down-counter that stops at zero; zero_o flags an expired interval.
module ddrx_wait_timer #(
  parameter int unsigned Width = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load_i,
  input  logic [Width-1:0] value_i,
  output logic             zero_o
);

  logic [Width-1:0] cnt_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= value_i;
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - Width'(1);
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/ddrx_mrs_sequencer.sv
// Issues MR2, MR3, MR1, MR0 (and optionally ZQCL) from a snapshot of the mode
// register values, spacing commands by tMRD / tMOD / tZQinit.
module ddrx_mrs_sequencer
  import ddrx_pkg::*;
#(
  parameter int unsigned TMRD    = 4,
  parameter int unsigned TMOD    = 12,
  parameter int unsigned TZQINIT = 512,
  parameter bit          ZQ_EN   = 1'b1
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   start_i,
  ddrx_mrs_sequencer_if.slave    cfg_if,
  output logic                   busy_o,
  output logic                   done_o
);

  localparam int unsigned CntW = $clog2(max3(TMRD, TMOD, TZQINIT) + 1);

  if (TMRD == 0 || TMOD == 0 || TZQINIT == 0) begin : g_bad_timing
    $error("ddrx_mrs_sequencer: timing parameters must be non-zero");
  end

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StDone} state_e;

  state_e          state_q;
  logic [2:0]      idx_q;
  msr_t            snap_q [4];
  logic            cmd_valid_q;
  cmd_t            cmd_q;
  logic [2:0]      ba_q;
  logic [15:0]     addr_q;
  logic            busy_q;
  logic            done_q;

  logic            accept;
  logic [CntW-1:0] dly;
  logic            last_step;
  logic            step_go;
  logic            tmr_load;
  logic [CntW-1:0] tmr_value;
  logic            tmr_zero;
  logic [2:0]      nxt_idx;
  logic            nxt_zq;
  msr_t            nxt_msr;

  always_comb begin
    accept    = (state_q == StIssue) && cmd_valid_q && cfg_if.cmd_ready;
    dly       = CntW'(TZQINIT);
    if (idx_q < 3'd3) begin
      dly = CntW'(TMRD);
    end else if (idx_q == 3'd3) begin
      dly = CntW'(TMOD);
    end
    last_step = (idx_q == 3'd4) || ((idx_q == 3'd3) && !ZQ_EN);
    // The command cycle counts as the first of the interval, so a delay of 1
    // re-issues straight away and longer delays park in StWait for dly-1 cycles.
    step_go   = (accept && (dly == CntW'(1))) || ((state_q == StWait) && tmr_zero);
    tmr_load  = accept && (dly != CntW'(1));
    tmr_value = dly - CntW'(2);
    nxt_idx   = idx_q + 3'd1;
    nxt_zq    = (nxt_idx == 3'd4);
    nxt_msr   = snap_q[mr_sel(nxt_idx)];
  end

  ddrx_wait_timer #(
    .Width (CntW)
  ) u_timer (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .load_i  (tmr_load),
    .value_i (tmr_value),
    .zero_o  (tmr_zero)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= StIdle;
      idx_q       <= '0;
      cmd_valid_q <= 1'b0;
      cmd_q       <= CMD_DESEL;
      ba_q        <= '0;
      addr_q      <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        snap_q[i] <= '0;
      end
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start_i) begin
            snap_q[0]   <= cfg_if.msr0;
            snap_q[1]   <= cfg_if.msr1;
            snap_q[2]   <= cfg_if.msr2;
            snap_q[3]   <= cfg_if.msr3;
            state_q     <= StIssue;
            idx_q       <= '0;
            cmd_valid_q <= 1'b1;
            cmd_q       <= CMD_MRS;
            ba_q        <= msr_ba(cfg_if.msr2);
            addr_q      <= msr_addr(cfg_if.msr2);
            busy_q      <= 1'b1;
            done_q      <= 1'b0;
          end
        end
        StIssue: begin
          if (accept && !step_go) begin
            state_q     <= StWait;
            cmd_valid_q <= 1'b0;
            cmd_q       <= CMD_DESEL;
            ba_q        <= '0;
            addr_q      <= '0;
          end
        end
        StWait: begin
        end
        StDone: begin
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase

      if (step_go) begin
        if (last_step) begin
          state_q     <= StDone;
          cmd_valid_q <= 1'b0;
          cmd_q       <= CMD_DESEL;
          ba_q        <= '0;
          addr_q      <= '0;
          busy_q      <= 1'b0;
          done_q      <= 1'b1;
        end else begin
          state_q     <= StIssue;
          idx_q       <= nxt_idx;
          cmd_valid_q <= 1'b1;
          cmd_q       <= nxt_zq ? CMD_ZQCL : CMD_MRS;
          ba_q        <= nxt_zq ? 3'd0 : msr_ba(nxt_msr);
          addr_q      <= nxt_zq ? ZQCL_ADDR : msr_addr(nxt_msr);
        end
      end
    end
  end

  assign cfg_if.cmd_valid = cmd_valid_q;
  assign cfg_if.cmd_cs_n  = cmd_q.cs_n;
  assign cfg_if.cmd_ras_n = cmd_q.ras_n;
  assign cfg_if.cmd_cas_n = cmd_q.cas_n;
  assign cfg_if.cmd_we_n  = cmd_q.we_n;
  assign cfg_if.cmd_ba    = ba_q;
  assign cfg_if.cmd_addr  = addr_q;
  assign busy_o           = busy_q;
  assign done_o           = done_q;

endmodule

// File: tb/tb_ddrx_mrs_sequencer.sv
// Scoreboarded bench for the MRS sequencer: one instance with ZQCL, one without.
module tb_ddrx_mrs_sequencer;
  import ddrx_pkg::*;

  localparam cmd_t EXP_MRS   = cmd_t'(4'b0000);
  localparam cmd_t EXP_ZQCL  = cmd_t'(4'b0110);
  localparam cmd_t EXP_DESEL = cmd_t'(4'b1111);

  localparam logic [18:0] M2 = 19'h2_0018;
  localparam logic [18:0] M3 = 19'h3_0000;
  localparam logic [18:0] M1 = 19'h1_0044;
  localparam logic [18:0] M0 = 19'h0_1D70;

  logic clk = 1'b0;
  logic rst, start_a, start_b, busy_a, done_a, busy_b, done_b;

  always #5 clk = ~clk;

  ddrx_mrs_sequencer_if if_a ();
  ddrx_mrs_sequencer_if if_b ();

  ddrx_mrs_sequencer u_dut_a (
    .clk_i   (clk),
    .rst_i   (rst),
    .start_i (start_a),
    .cfg_if  (if_a),
    .busy_o  (busy_a),
    .done_o  (done_a)
  );

  ddrx_mrs_sequencer #(
    .ZQ_EN (1'b0)
  ) u_dut_b (
    .clk_i   (clk),
    .rst_i   (rst),
    .start_i (start_b),
    .cfg_if  (if_b),
    .busy_o  (busy_b),
    .done_o  (done_b)
  );

  typedef struct {
    cmd_t        enc;
    logic [2:0]  ba;
    logic [15:0] addr;
    int          gap;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   last_acc = 0;
  int   n_acc = 0;
  int   done_rises = 0;
  int   done_cyc = 0;
  logic prev_valid = 1'b0;
  logic prev_done = 1'b0;
  cmd_t enc_a, enc_b;

  assign enc_a = {if_a.cmd_cs_n, if_a.cmd_ras_n, if_a.cmd_cas_n, if_a.cmd_we_n};
  assign enc_b = {if_b.cmd_cs_n, if_b.cmd_ras_n, if_b.cmd_cas_n, if_b.cmd_we_n};

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard for instance A: every bus cycle is checked against the queue front.
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      exp_q.delete();
      prev_valid = 1'b0;
      prev_done  = 1'b0;
    end else begin
      total++;
      if (if_a.cmd_valid) begin
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL unexpected_cmd: got enc=%b ba=%0h addr=%h, want no command",
                   enc_a, if_a.cmd_ba, if_a.cmd_addr);
          if (if_a.cmd_ready) begin
            last_acc = cyc;
            n_acc++;
          end
        end else begin
          e = exp_q[0];
          if ({enc_a, if_a.cmd_ba, if_a.cmd_addr} !== {e.enc, e.ba, e.addr}) begin
            bad++;
            $display("FAIL cmd_payload: got enc=%b ba=%0h addr=%h, want enc=%b ba=%0h addr=%h",
                     enc_a, if_a.cmd_ba, if_a.cmd_addr, e.enc, e.ba, e.addr);
          end
          if (!prev_valid && e.gap != 0) begin
            total++;
            if (cyc - last_acc != e.gap) begin
              bad++;
              $display("FAIL cmd_spacing: got %0d cycles, want %0d", cyc - last_acc, e.gap);
            end
          end
          if (if_a.cmd_ready) begin
            void'(exp_q.pop_front());
            last_acc = cyc;
            n_acc++;
          end
        end
      end else if (enc_a !== EXP_DESEL || if_a.cmd_ba !== 3'd0 || if_a.cmd_addr !== 16'd0) begin
        bad++;
        $display("FAIL idle_bus: got enc=%b ba=%0h addr=%h, want 1111/0/0000",
                 enc_a, if_a.cmd_ba, if_a.cmd_addr);
      end
      if (done_a && !prev_done) begin
        done_rises++;
        done_cyc = cyc;
      end
      prev_valid = if_a.cmd_valid;
      prev_done  = done_a;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_start_a();
    start_a = 1'b1;
    tick(1);
    start_a = 1'b0;
  endtask

  task automatic push_seq(input logic [18:0] m2, input logic [18:0] m3,
                          input logic [18:0] m1, input logic [18:0] m0);
    exp_q.push_back('{enc: EXP_MRS, ba: m2[18:16], addr: m2[15:0], gap: 0});
    exp_q.push_back('{enc: EXP_MRS, ba: m3[18:16], addr: m3[15:0], gap: 4});
    exp_q.push_back('{enc: EXP_MRS, ba: m1[18:16], addr: m1[15:0], gap: 4});
    exp_q.push_back('{enc: EXP_MRS, ba: m0[18:16], addr: m0[15:0], gap: 4});
    exp_q.push_back('{enc: EXP_ZQCL, ba: 3'd0, addr: 16'h0400, gap: 12});
  endtask

  task automatic wait_acc(input int target, input int bound, input string name);
    for (int i = 0; i < bound && n_acc < target; i++) tick(1);
    total++;
    if (n_acc < target) begin
      bad++;
      $display("FAIL %s: accepted=%0d, want %0d", name, n_acc, target);
    end
  endtask

  task automatic wait_done_a(input int bound, input string name);
    for (int i = 0; i < bound && done_a !== 1'b1; i++) tick(1);
    total++;
    if (done_a !== 1'b1) begin
      bad++;
      $display("FAIL %s: done=%b after %0d cycles, want 1", name, done_a, bound);
    end
  endtask

  task automatic check_full_run(input int n0, input string name);
    total++;
    if (n_acc - n0 !== 5) begin
      bad++;
      $display("FAIL %s_count: got %0d commands, want 5", name, n_acc - n0);
    end
    total++;
    if (done_cyc - last_acc !== 512) begin
      bad++;
      $display("FAIL %s_tzqinit: got %0d cycles, want 512", name, done_cyc - last_acc);
    end
    total++;
    if (busy_a !== 1'b0 || exp_q.size() !== 0) begin
      bad++;
      $display("FAIL %s_end: busy=%b pending=%0d, want busy=0 pending=0",
               name, busy_a, exp_q.size());
    end
  endtask

  task automatic check_reset_outputs(input string name);
    total++;
    if (if_a.cmd_valid !== 1'b0 || enc_a !== EXP_DESEL || if_a.cmd_ba !== 3'd0 ||
        if_a.cmd_addr !== 16'd0 || busy_a !== 1'b0 || done_a !== 1'b0) begin
      bad++;
      $display("FAIL %s: got v=%b enc=%b ba=%0h addr=%h busy=%b done=%b, want 0/1111/0/0000/0/0",
               name, if_a.cmd_valid, enc_a, if_a.cmd_ba, if_a.cmd_addr, busy_a, done_a);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(2);
    check_reset_outputs("reset_a");
    total++;
    if (if_b.cmd_valid !== 1'b0 || enc_b !== EXP_DESEL || busy_b !== 1'b0 ||
        done_b !== 1'b0) begin
      bad++;
      $display("FAIL reset_b: got v=%b enc=%b busy=%b done=%b, want 0/1111/0/0",
               if_b.cmd_valid, enc_b, busy_b, done_b);
    end
    rst = 1'b0;
    tick(3);
  endtask

  task automatic test_basic();
    int n0 = n_acc;
    push_seq(M2, M3, M1, M0);
    pulse_start_a();
    total++;
    if (busy_a !== 1'b1 || done_a !== 1'b0) begin
      bad++;
      $display("FAIL basic_busy: got busy=%b done=%b, want 1/0", busy_a, done_a);
    end
    wait_done_a(1000, "basic_done");
    tick(3);
    check_full_run(n0, "basic");
    total++;
    if (done_a !== 1'b1) begin
      bad++;
      $display("FAIL basic_sticky: got done=%b, want 1", done_a);
    end
  endtask

  task automatic test_stall();
    int n0 = n_acc;
    push_seq(M2, M3, M1, M0);
    pulse_start_a();
    wait_acc(n0 + 1, 50, "stall_mr2");
    if_a.cmd_ready = 1'b0;
    for (int i = 0; i < 20 && !if_a.cmd_valid; i++) tick(1);
    tick(7);
    total++;
    if (if_a.cmd_valid !== 1'b1 || if_a.cmd_ba !== 3'd3 || n_acc - n0 !== 1) begin
      bad++;
      $display("FAIL stall_hold: got v=%b ba=%0h accepted=%0d, want v=1 ba=3 accepted=1",
               if_a.cmd_valid, if_a.cmd_ba, n_acc - n0);
    end
    if_a.cmd_ready = 1'b1;
    wait_done_a(1000, "stall_done");
    tick(2);
    check_full_run(n0, "stall");
  endtask

  task automatic test_snapshot();
    int n0 = n_acc;
    push_seq(M2, M3, M1, M0);
    pulse_start_a();
    if_a.msr0 = 19'h0_0000;
    wait_done_a(1000, "snap_done");
    tick(2);
    check_full_run(n0, "snap");
    if_a.msr0 = M0;
  endtask

  task automatic test_start_while_busy();
    int n0 = n_acc;
    int d0 = done_rises;
    push_seq(M2, M3, M1, M0);
    pulse_start_a();
    wait_acc(n0 + 1, 50, "busy_mr2");
    pulse_start_a();
    wait_acc(n0 + 5, 100, "busy_zq");
    tick(20);
    pulse_start_a();
    wait_done_a(1000, "busy_done");
    pulse_start_a();
    tick(30);
    check_full_run(n0, "busy");
    total++;
    if (done_rises - d0 !== 1 || done_a !== 1'b1) begin
      bad++;
      $display("FAIL busy_done_once: got rises=%0d done=%b, want 1/1", done_rises - d0, done_a);
    end
  endtask

  task automatic test_restart();
    int n0 = n_acc;
    push_seq(M2, M3, M1, M0);
    pulse_start_a();
    total++;
    if (done_a !== 1'b0 || busy_a !== 1'b1) begin
      bad++;
      $display("FAIL restart_clear: got done=%b busy=%b, want 0/1", done_a, busy_a);
    end
    wait_done_a(1000, "restart_done");
    tick(2);
    check_full_run(n0, "restart");
  endtask

  task automatic test_reset_mid();
    int n0 = n_acc;
    push_seq(M2, M3, M1, M0);
    pulse_start_a();
    wait_acc(n0 + 5, 100, "rstmid_zq");
    tick(100);
    rst = 1'b1;
    tick(1);
    check_reset_outputs("rstmid_outputs");
    rst = 1'b0;
    tick(10);
    n0 = n_acc;
    push_seq(M2, M3, M1, M0);
    pulse_start_a();
    wait_done_a(1000, "rstmid_done");
    tick(2);
    check_full_run(n0, "rstmid");
  endtask

  task automatic test_zq_disabled();
    logic [18:0] seq [4];
    int k = 0;
    int last = 0;
    int dcyc = -1;
    seq[0] = M2;
    seq[1] = M3;
    seq[2] = M1;
    seq[3] = M0;
    start_b = 1'b1;
    tick(1);
    start_b = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if (done_b === 1'b1) begin
        dcyc = cyc;
        break;
      end
      if (if_b.cmd_valid && if_b.cmd_ready) begin
        total++;
        if (k >= 4) begin
          bad++;
          $display("FAIL nozq_extra: got enc=%b addr=%h, want no command", enc_b, if_b.cmd_addr);
        end else if ({enc_b, if_b.cmd_ba, if_b.cmd_addr} !== {EXP_MRS, seq[k]}) begin
          bad++;
          $display("FAIL nozq_cmd%0d: got enc=%b ba=%0h addr=%h, want enc=0000 ba=%0h addr=%h",
                   k, enc_b, if_b.cmd_ba, if_b.cmd_addr, seq[k][18:16], seq[k][15:0]);
        end
        k++;
        last = cyc;
      end
      tick(1);
    end
    total++;
    if (k !== 4) begin
      bad++;
      $display("FAIL nozq_count: got %0d commands, want 4", k);
    end
    total++;
    if (dcyc - last !== 12) begin
      bad++;
      $display("FAIL nozq_tmod: got done %0d cycles after MR0, want 12", dcyc - last);
    end
  endtask

  initial begin
    rst     = 1'b1;
    start_a = 1'b0;
    start_b = 1'b0;
    if_a.msr0 = M0;
    if_a.msr1 = M1;
    if_a.msr2 = M2;
    if_a.msr3 = M3;
    if_a.cmd_ready = 1'b1;
    if_b.msr0 = M0;
    if_b.msr1 = M1;
    if_b.msr2 = M2;
    if_b.msr3 = M3;
    if_b.cmd_ready = 1'b1;
    test_reset();
    test_basic();
    test_stall();
    test_snapshot();
    test_start_while_busy();
    test_restart();
    test_reset_mid();
    test_zq_disabled();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
